// File: rtl/digit_row_renderer.sv
// Streams one frame of large 7-segment BCD digits as SSD1306 page bytes, horizontal addressing order.
// Decoder drive (segments/index) is registered one stage ahead of the valid/ready output byte register.
module digit_row_renderer #(
  parameter int DIGITS        = 5,
  parameter int GAP_COLUMNS   = 3,
  parameter int DIGIT_COLUMNS = 21
) (
  input  logic                  clk_in,
  input  logic                  reset_n_in,
  input  logic                  start_in,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic                  blank_zeros_in,
  output logic [6:0]            segments_out,
  output logic [4:0]            index_x_out,
  output logic [1:0]            index_y_out,
  input  logic [7:0]            pixels_in,
  output logic [7:0]            data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  last_out,
  output logic                  busy_out
);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int GW = (GAP_COLUMNS > 1) ? $clog2(GAP_COLUMNS) : 1;
  localparam logic [4:0]    X_LAST = 5'(DIGIT_COLUMNS - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DIGITS - 1);
  localparam logic [GW-1:0] G_LAST = GW'((GAP_COLUMNS > 0) ? GAP_COLUMNS - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN} state_t;
  state_t r_state, w_state_nxt;

  logic [4*DIGITS-1:0] r_digits;
  logic                r_blank;
  logic [6:0]          r_mask [DIGITS];
  logic [6:0]          w_mask [DIGITS];

  logic [1:0]    r_page;
  logic [DW-1:0] r_digit;
  logic [4:0]    r_x;
  logic [GW-1:0] r_gap;
  logic          r_in_gap;
  logic          r_walk_done;

  logic [6:0] r_seg;
  logic [4:0] r_ix;
  logic [1:0] r_iy;
  logic       r_drv_vld;
  logic       r_drv_gap;
  logic       r_drv_last;

  logic [7:0] r_dat;
  logic       r_vld;
  logic       r_last;

  logic w_walk_en, w_drv_load, w_out_load, w_col_last, w_busy;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h40;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // A digit is a leading zero while every digit to its left (and itself) is zero.
  always_comb begin : mask_calc
    logic       w_lead;
    logic [3:0] w_nib;
    w_lead = 1'b1;
    w_nib  = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      w_nib     = r_digits[4*(DIGITS-1-i) +: 4];
      w_lead    = w_lead && (w_nib == 4'h0);
      w_mask[i] = (r_blank && w_lead && (i != DIGITS - 1)) ? 7'h00 : seg7(w_nib);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start_in) w_state_nxt = S_LOAD;
      S_LOAD:   w_state_nxt = S_STREAM;
      S_STREAM: if (w_out_load && r_drv_last) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (r_vld && ready_in) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy    = (r_state != S_IDLE);
    w_walk_en = (r_state == S_STREAM) && !r_walk_done;
  end

  assign w_out_load = r_drv_vld && (!r_vld || ready_in);
  assign w_drv_load = w_walk_en && (!r_drv_vld || w_out_load);
  assign w_col_last = !r_in_gap && (r_x == X_LAST) && (r_digit == D_LAST) && (r_page == 2'd3);

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      r_digits    <= '0;
      r_blank     <= 1'b0;
      for (int i = 0; i < DIGITS; i++) r_mask[i] <= 7'h00;
      r_page      <= '0;
      r_digit     <= '0;
      r_x         <= '0;
      r_gap       <= '0;
      r_in_gap    <= 1'b0;
      r_walk_done <= 1'b0;
      r_seg       <= 7'h00;
      r_ix        <= '0;
      r_iy        <= '0;
      r_drv_vld   <= 1'b0;
      r_drv_gap   <= 1'b0;
      r_drv_last  <= 1'b0;
      r_dat       <= 8'h00;
      r_vld       <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start_in) begin
        r_digits <= digits_in;
        r_blank  <= blank_zeros_in;
      end

      if (r_state == S_LOAD) begin
        for (int i = 0; i < DIGITS; i++) r_mask[i] <= w_mask[i];
        r_page      <= '0;
        r_digit     <= '0;
        r_x         <= '0;
        r_gap       <= '0;
        r_in_gap    <= 1'b0;
        r_walk_done <= 1'b0;
      end else if (w_drv_load) begin
        // Nested column walk: x inside a digit, then the gap, then the next digit or page.
        if (r_in_gap) begin
          if (r_gap == G_LAST) begin
            r_gap    <= '0;
            r_in_gap <= 1'b0;
            r_digit  <= r_digit + 1'b1;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end else if (r_x == X_LAST) begin
          r_x <= '0;
          if (r_digit == D_LAST) begin
            r_digit <= '0;
            r_page  <= r_page + 1'b1;
            if (r_page == 2'd3) r_walk_done <= 1'b1;
          end else if (GAP_COLUMNS > 0) begin
            r_in_gap <= 1'b1;
          end else begin
            r_digit <= r_digit + 1'b1;
          end
        end else begin
          r_x <= r_x + 1'b1;
        end
      end

      if (w_drv_load) begin
        r_seg      <= r_in_gap ? 7'h00 : r_mask[r_digit];
        r_ix       <= r_x;
        r_iy       <= r_page;
        r_drv_vld  <= 1'b1;
        r_drv_gap  <= r_in_gap;
        r_drv_last <= w_col_last;
      end else if (w_out_load) begin
        r_drv_vld  <= 1'b0;
        r_drv_last <= 1'b0;
        r_seg      <= 7'h00;
      end

      if (w_out_load) begin
        r_dat  <= r_drv_gap ? 8'h00 : pixels_in;
        r_vld  <= 1'b1;
        r_last <= r_drv_last;
      end else if (ready_in) begin
        r_vld  <= 1'b0;
        r_last <= 1'b0;
      end
    end
  end

  assign segments_out = r_seg;
  assign index_x_out  = r_ix;
  assign index_y_out  = r_iy;
  assign data_out     = r_dat;
  assign valid_out    = r_vld;
  assign last_out     = r_last;
  assign busy_out     = w_busy;

endmodule

// File: tb/tb_digit_row_renderer.sv
// Bench for digit_row_renderer: models the 21x32 segment decoder and the expected frame from the digit rules.
module tb_digit_row_renderer;
  localparam int W     = 117;
  localparam int FRAME = 4 * W;

  logic        clk_in = 1'b0;
  logic        reset_n_in;
  logic        start_in;
  logic [19:0] digits_in;
  logic        blank_zeros_in;
  logic [6:0]  segments_out;
  logic [4:0]  index_x_out;
  logic [1:0]  index_y_out;
  logic [7:0]  pixels_in;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        ready_in;
  logic        last_out;
  logic        busy_out;

  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] cap  [0:511];
  logic [7:0] ref2 [0:FRAME-1];
  int ncap;

  digit_row_renderer dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .start_in(start_in), .digits_in(digits_in),
    .blank_zeros_in(blank_zeros_in), .segments_out(segments_out), .index_x_out(index_x_out),
    .index_y_out(index_y_out), .pixels_in(pixels_in), .data_out(data_out), .valid_out(valid_out),
    .ready_in(ready_in), .last_out(last_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  // Segment geometry: a/d bars have bevelled ends, g spans the page 1/2 boundary.
  function automatic bit lit(input logic [6:0] s, input int x, input int r);
    bit on = 0;
    if (s[0] && r >= 1 && r <= 4 && x >= 5 && x <= 15 && ((x >= 7 && x <= 13) || r <= 2)) on = 1;
    if (s[1] && x >= 15 && x <= 18 && r >= 5 && r <= 14) on = 1;
    if (s[2] && x >= 15 && x <= 18 && r >= 17 && r <= 26) on = 1;
    if (s[3] && r >= 27 && r <= 30 && x >= 5 && x <= 15 && ((x >= 7 && x <= 13) || r >= 29)) on = 1;
    if (s[4] && x >= 2 && x <= 5 && r >= 17 && r <= 26) on = 1;
    if (s[5] && x >= 2 && x <= 5 && r >= 5 && r <= 14) on = 1;
    if (s[6] && x >= 7 && x <= 13 && r >= 14 && r <= 17) on = 1;
    return on;
  endfunction

  function automatic logic [7:0] pix(input logic [6:0] s, input int x, input int page);
    logic [7:0] b = 8'h00;
    for (int i = 0; i < 8; i++) b[i] = lit(s, x, page * 8 + i);
    return b;
  endfunction

  always_comb pixels_in = pix(segments_out, int'(index_x_out), int'(index_y_out));

  function automatic logic [6:0] code(input logic [3:0] n);
    logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    return t[n];
  endfunction

  function automatic logic [3:0] nib(input logic [19:0] d, input int k);
    logic [19:0] sh = d >> (4 * (4 - k));
    return sh[3:0];
  endfunction

  function automatic logic [6:0] mask_of(input logic [19:0] d, input logic b, input int k);
    bit lead = 1;
    for (int i = 0; i <= k; i++) if (nib(d, i) != 4'h0) lead = 0;
    if (b && lead && k != 4) return 7'h00;
    return code(nib(d, k));
  endfunction

  function automatic logic [7:0] model(input logic [19:0] d, input logic b, input int idx);
    int page = idx / W;
    int col  = idx % W;
    int dg   = col / 24;
    int cx   = col % 24;
    if (cx >= 21) return 8'h00;
    return pix(mask_of(d, b, dg), cx, page);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Runs one frame starting at a negedge; returns at a negedge after the frame ends (or aborts).
  task automatic run_frame(input logic [19:0] d, input logic b, input int stall_at, input int stall_len,
                           input bit rnd, input int pulse_at, input int abort_at, input string nm);
    int first_v = -1, nlast = 0, lastpos = -1, gaps = 0, stall_left = 0, nbad = 0;
    bit done = 0, aborted = 0, prev_stall = 0, stalled = 0;
    logic [7:0] pd = 8'h00;
    logic pv = 1'b0, pl = 1'b0;
    ncap = 0;
    digits_in = d; blank_zeros_in = b; start_in = 1'b1; ready_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    digits_in = 20'($urandom); blank_zeros_in = ~b;
    chk({nm, " busy after start"}, busy_out, 1);
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      if (prev_stall) begin
        chk({nm, " stall hold"}, {valid_out, last_out, data_out}, {pv, pl, pd});
      end
      if (abort_at >= 0 && ncap == abort_at) begin
        reset_n_in = 1'b0;
        @(negedge clk_in);
        chk({nm, " abort valid/busy/last"}, {valid_out, busy_out, last_out}, 3'b000);
        reset_n_in = 1'b1;
        aborted = 1;
        break;
      end
      if (stall_at >= 0 && ncap == stall_at && !stalled) begin
        stall_left = stall_len;
        stalled = 1;
      end
      if (stall_left > 0) begin
        ready_in = 1'b0;
        stall_left--;
      end else begin
        ready_in = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      start_in = (pulse_at >= 0 && ncap == pulse_at);
      if (valid_out && first_v < 0) first_v = cyc;
      if (first_v >= 0 && !valid_out) gaps++;
      if (valid_out && ready_in) begin
        if (ncap < 512) cap[ncap] = data_out;
        if (last_out) begin
          nlast++;
          lastpos = ncap;
          done = 1;
        end
        ncap++;
      end
      pd = data_out; pv = valid_out; pl = last_out;
      prev_stall = valid_out && !ready_in;
      @(negedge clk_in);
    end
    start_in = 1'b0;
    ready_in = 1'b1;
    if (aborted) begin
      chk({nm, " no last before abort"}, nlast, 0);
      return;
    end
    chk({nm, " completed in budget"}, done, 1);
    chk({nm, " first valid latency"}, first_v, 3);
    chk({nm, " valid bubbles"}, gaps, 0);
    chk({nm, " byte count"}, ncap, FRAME);
    chk({nm, " last count/pos"}, {nlast, lastpos}, {32'd1, 32'(FRAME - 1)});
    chk({nm, " idle after frame"}, {valid_out, busy_out, last_out}, 3'b000);
    for (int i = 0; i < FRAME && i < ncap; i++) if (cap[i] !== model(d, b, i)) nbad++;
    chk({nm, " bytes vs model"}, nbad, 0);
  endtask

  typedef struct {
    logic [19:0] d;
    logic        b;
    int          idx;
    logic [7:0]  exp;
  } spot_t;

  initial begin
    spot_t spots [17];
    logic [19:0] pd_last;
    logic pb_last;
    bit have = 0;
    int nbad;
    spots = '{
      '{20'h80000, 1'b0, 5,         8'hE6}, '{20'h80000, 1'b0, 7,       8'h1E},
      '{20'h80000, 1'b0, W + 8,     8'hC0}, '{20'h80000, 1'b0, 21,      8'h00},
      '{20'h80000, 1'b0, 22,        8'h00}, '{20'h80000, 1'b0, 23,      8'h00},
      '{20'h80000, 1'b0, 24 + 7,    8'h1E}, '{20'h00070, 1'b1, 72 + 7,  8'h1E},
      '{20'h00070, 1'b1, 7,         8'h00}, '{20'h00070, 1'b1, 48 + 7,  8'h00},
      '{20'h00070, 1'b1, 96 + 7,    8'h1E}, '{20'h00000, 1'b1, 96 + 7,  8'h1E},
      '{20'h00000, 1'b1, 72 + 7,    8'h00}, '{20'hA0000, 1'b0, W + 8,   8'hC0},
      '{20'hA0000, 1'b0, 2 * W + 8, 8'h03}, '{20'hA0000, 1'b0, 3 * W + 8, 8'h00},
      '{20'hA0000, 1'b0, 7,         8'h00}
    };

    reset_n_in = 1'b0; start_in = 1'b1; ready_in = 1'b1;
    digits_in = 20'h80000; blank_zeros_in = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("reset outputs", {valid_out, busy_out, last_out, data_out, segments_out}, 18'h0);
    reset_n_in = 1'b1; start_in = 1'b0;
    repeat (5) @(negedge clk_in);
    chk("idle without start", {busy_out, valid_out}, 2'b00);

    for (int i = 0; i < 17; i++) begin
      if (!have || spots[i].d != pd_last || spots[i].b != pb_last) begin
        run_frame(spots[i].d, spots[i].b, -1, 0, 0, -1, -1, $sformatf("frame %05h", spots[i].d));
        pd_last = spots[i].d; pb_last = spots[i].b; have = 1;
        if (spots[i].d == 20'h80000 && !spots[i].b)
          for (int k = 0; k < FRAME; k++) ref2[k] = cap[k];
      end
      chk($sformatf("spot %05h byte %0d", spots[i].d, spots[i].idx), cap[spots[i].idx], spots[i].exp);
    end

    run_frame(20'h80000, 1'b0, 100, 5, 0, -1, -1, "stall");
    nbad = 0;
    for (int k = 0; k < FRAME; k++) if (cap[k] !== ref2[k]) nbad++;
    chk("stall stream equals unstalled", nbad, 0);

    run_frame(20'h80000, 1'b0, -1, 0, 0, 50, -1, "start ignored");
    run_frame(20'h12345, 1'b0, -1, 0, 0, -1, 200, "abort");
    run_frame(20'h09876, 1'b1, -1, 0, 0, -1, -1, "after abort");

    for (int r = 0; r < 6; r++) begin
      logic [19:0] rd = '0;
      for (int k = 0; k < 5; k++) rd = {rd[15:0], 4'($urandom_range(0, (r % 2) ? 15 : 10))};
      if (r == 0) rd[19:8] = 12'h000;
      run_frame(rd, 1'($urandom_range(0, 1)), -1, 0, 1, -1, -1, $sformatf("random %05h", rd));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
